// File: rtl/rf_wr_arb_if.sv
// rf_wr_arb_if: bundle between two write requesters, the write arbiter and
// the register bank it feeds.
//   a_req/a_lock/a_addr/a_data : requester A write request, lock and payload
//   a_gnt                      : A write accepted this cycle
//   b_*                        : same set for requester B
//   rf_write                   : one-hot per-register write strobe
//   rf_writedata               : shared write data
//   owner                      : 00 idle, 01 A locked, 10 B locked
// Modports: master = requester/bank side, slave = arbiter side.
interface rf_wr_arb_if #(
  parameter int NREG = 8,
  parameter int AW   = 3,
  parameter int DW   = 16
);
  logic            a_req;
  logic            a_lock;
  logic [AW-1:0]   a_addr;
  logic [DW-1:0]   a_data;
  logic            a_gnt;
  logic            b_req;
  logic            b_lock;
  logic [AW-1:0]   b_addr;
  logic [DW-1:0]   b_data;
  logic            b_gnt;
  logic [NREG-1:0] rf_write;
  logic [DW-1:0]   rf_writedata;
  logic [1:0]      owner;

  modport master (
    output a_req, a_lock, a_addr, a_data,
    output b_req, b_lock, b_addr, b_data,
    input  a_gnt, b_gnt, rf_write, rf_writedata, owner
  );

  modport slave (
    input  a_req, a_lock, a_addr, a_data,
    input  b_req, b_lock, b_addr, b_data,
    output a_gnt, b_gnt, rf_write, rf_writedata, owner
  );
endinterface

// File: rtl/rf_wr_arb.sv
// rf_wr_arb: shares the write port of an NREG x DW register bank between
// requesters A and B. Round-robin on ties, with optional locked bursts whose
// tenure is capped at MAX_BURST cycles (first grant included).
// Ports:
//   clk  : rising-edge clock
//   rst  : asynchronous, active-high reset
//   bus  : rf_wr_arb_if.slave (requests in; grants, write strobe/data and
//          owner out). Grants are combinational in the request cycle; owner
//          is registered.
module rf_wr_arb #(
  parameter int NREG      = 8,
  parameter int AW        = 3,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          clk,
  input  logic          rst,
  rf_wr_arb_if.slave    bus
);

  localparam int CW = $clog2(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    OWN_A = 2'b01,
    OWN_B = 2'b10
  } fsm_e;

  fsm_e            fsm_r;
  fsm_e            fsm_nxt_s;
  logic            last_r;      // 1 = B was served last
  logic            last_nxt_s;
  logic [CW-1:0]   cnt_r;       // tenure cycles of the current locked owner
  logic [CW-1:0]   cnt_nxt_s;
  logic            a_gnt_s;
  logic            b_gnt_s;
  logic [AW-1:0]   sel_addr_s;
  logic [DW-1:0]   sel_data_s;
  logic [NREG-1:0] wr_s;

  // Arbiter state registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_r  <= IDLE;
      last_r <= 1'b1;
      cnt_r  <= {CW{1'b0}};
    end else begin
      fsm_r  <= fsm_nxt_s;
      last_r <= last_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  // Grant decision and next-state logic
  always_comb begin
    a_gnt_s    = 1'b0;
    b_gnt_s    = 1'b0;
    fsm_nxt_s  = fsm_r;
    last_nxt_s = last_r;
    cnt_nxt_s  = cnt_r;
    case (fsm_r)
      IDLE: begin
        // A wins a tie only when B was served last
        if (bus.a_req && (!bus.b_req || last_r)) begin
          a_gnt_s    = 1'b1;
          last_nxt_s = 1'b0;
          if (bus.a_lock) begin
            fsm_nxt_s = OWN_A;
            cnt_nxt_s = CW'(1);
          end else begin
            fsm_nxt_s = IDLE;
          end
        end else if (bus.b_req) begin
          b_gnt_s    = 1'b1;
          last_nxt_s = 1'b1;
          if (bus.b_lock) begin
            fsm_nxt_s = OWN_B;
            cnt_nxt_s = CW'(1);
          end else begin
            fsm_nxt_s = IDLE;
          end
        end else begin
          fsm_nxt_s = IDLE;
        end
      end
      OWN_A: begin
        a_gnt_s   = bus.a_req;
        cnt_nxt_s = cnt_r + CW'(1);
        // Cap forces release even if lock is still held
        if (!bus.a_lock || (cnt_r == CW'(MAX_BURST - 1))) begin
          fsm_nxt_s = IDLE;
          cnt_nxt_s = {CW{1'b0}};
        end else begin
          fsm_nxt_s = OWN_A;
        end
      end
      OWN_B: begin
        b_gnt_s   = bus.b_req;
        cnt_nxt_s = cnt_r + CW'(1);
        if (!bus.b_lock || (cnt_r == CW'(MAX_BURST - 1))) begin
          fsm_nxt_s = IDLE;
          cnt_nxt_s = {CW{1'b0}};
        end else begin
          fsm_nxt_s = OWN_B;
        end
      end
      default: begin
        fsm_nxt_s = IDLE;
        cnt_nxt_s = {CW{1'b0}};
      end
    endcase
    // No write may be accepted while reset is held
    if (rst) begin
      a_gnt_s = 1'b0;
      b_gnt_s = 1'b0;
    end else begin
      a_gnt_s = a_gnt_s;
      b_gnt_s = b_gnt_s;
    end
  end

  // Write datapath: steer the granted requester onto the bank
  always_comb begin
    sel_addr_s = {AW{1'b0}};
    sel_data_s = {DW{1'b0}};
    if (a_gnt_s) begin
      sel_addr_s = bus.a_addr;
      sel_data_s = bus.a_data;
    end else if (b_gnt_s) begin
      sel_addr_s = bus.b_addr;
      sel_data_s = bus.b_data;
    end else begin
      sel_addr_s = {AW{1'b0}};
      sel_data_s = {DW{1'b0}};
    end
    // Out-of-range addresses match no strobe, so the write is dropped
    for (int i = 0; i < NREG; i++) begin
      wr_s[i] = (a_gnt_s | b_gnt_s) && (sel_addr_s == AW'(i));
    end
  end

  assign bus.a_gnt        = a_gnt_s;
  assign bus.b_gnt        = b_gnt_s;
  assign bus.rf_write     = wr_s;
  assign bus.rf_writedata = sel_data_s;
  assign bus.owner        = fsm_r;

endmodule

// File: tb/tb_rf_wr_arb.sv
// Directed testbench for rf_wr_arb (NREG=6, MAX_BURST=4). The stimulus
// process pushes one expected output set per driven cycle; a monitor on the
// falling edge pops and compares. A small behavioural bank captures writes.
module tb_rf_wr_arb;
  localparam int NREG = 6;
  localparam int AW   = 3;
  localparam int DW   = 16;

  typedef struct {
    int              id;
    logic            a_gnt;
    logic            b_gnt;
    logic [NREG-1:0] wr;
    logic [DW-1:0]   wd;
    logic [1:0]      owner;
  } exp_t;

  logic clk;
  logic rst;
  exp_t exp_q[$];
  int   n_checks;
  int   n_fail;
  int   step_id;
  logic [DW-1:0] bank [NREG];

  rf_wr_arb_if #(.NREG(NREG), .AW(AW), .DW(DW)) bus ();

  rf_wr_arb #(.NREG(NREG), .AW(AW), .DW(DW), .MAX_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural register bank fed by the arbiter
  always @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (bus.rf_write[i]) bank[i] <= bus.rf_writedata;
    end
  end

  task automatic check(input string name, input int id,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, id, act, exp);
    end
  endtask

  // Monitor: compare every cycle that has a pending expectation
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("a_gnt",        e.id, 32'(bus.a_gnt),        32'(e.a_gnt));
      check("b_gnt",        e.id, 32'(bus.b_gnt),        32'(e.b_gnt));
      check("rf_write",     e.id, 32'(bus.rf_write),     32'(e.wr));
      check("rf_writedata", e.id, 32'(bus.rf_writedata), 32'(e.wd));
      check("owner",        e.id, 32'(bus.owner),        32'(e.owner));
    end
  end

  task automatic step(input logic r,
                      input logic ar, input logic al, input logic [2:0] aa, input logic [15:0] ad,
                      input logic br, input logic bl, input logic [2:0] ba, input logic [15:0] bd,
                      input logic ea, input logic eb, input logic [5:0] ew,
                      input logic [15:0] ed, input logic [1:0] eo);
    exp_t e;
    rst        = r;
    bus.a_req  = ar;
    bus.a_lock = al;
    bus.a_addr = aa;
    bus.a_data = ad;
    bus.b_req  = br;
    bus.b_lock = bl;
    bus.b_addr = ba;
    bus.b_data = bd;
    e.id = step_id; e.a_gnt = ea; e.b_gnt = eb; e.wr = ew; e.wd = ed; e.owner = eo;
    exp_q.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic check_bank(input string name, input logic [15:0] r0, input logic [15:0] r1,
                            input logic [15:0] r2, input logic [15:0] r3,
                            input logic [15:0] r4, input logic [15:0] r5);
    logic [15:0] exp_b [NREG];
    exp_b[0] = r0; exp_b[1] = r1; exp_b[2] = r2;
    exp_b[3] = r3; exp_b[4] = r4; exp_b[5] = r5;
    for (int i = 0; i < NREG; i++) check(name, i, 32'(bank[i]), 32'(exp_b[i]));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    step_id  = 0;
    for (int i = 0; i < NREG; i++) bank[i] = 16'h0000;
    rst = 1'b1;
    bus.a_req = 1'b0; bus.a_lock = 1'b0; bus.a_addr = 3'd0; bus.a_data = 16'h0000;
    bus.b_req = 1'b0; bus.b_lock = 1'b0; bus.b_addr = 3'd0; bus.b_data = 16'h0000;
    @(posedge clk);
    #1;

    // Reset held with both requesting: nothing granted
    //    r  ar al aa   ad        br bl ba   bd        ea eb ew     ed        eo
    step(1, 1, 0, 3'd2, 16'h1111, 1, 0, 3'd5, 16'h2222, 0, 0, 6'h00, 16'h0000, 2'b00);
    step(1, 1, 0, 3'd2, 16'h1111, 1, 0, 3'd5, 16'h2222, 0, 0, 6'h00, 16'h0000, 2'b00);

    // Tie round-robin, A first after reset
    step(0, 1, 0, 3'd2, 16'h1111, 1, 0, 3'd5, 16'h2222, 1, 0, 6'h04, 16'h1111, 2'b00);
    step(0, 1, 0, 3'd2, 16'h1111, 1, 0, 3'd5, 16'h2222, 0, 1, 6'h20, 16'h2222, 2'b00);
    step(0, 1, 0, 3'd2, 16'h1111, 1, 0, 3'd5, 16'h2222, 1, 0, 6'h04, 16'h1111, 2'b00);
    step(0, 1, 0, 3'd2, 16'h1111, 1, 0, 3'd5, 16'h2222, 0, 1, 6'h20, 16'h2222, 2'b00);
    check_bank("bank_rr", 16'h0000, 16'h0000, 16'h1111, 16'h0000, 16'h0000, 16'h2222);

    // Locked burst: A holds 4 cycles, then B, then A again
    step(0, 1, 1, 3'd0, 16'hA000, 1, 0, 3'd1, 16'hB001, 1, 0, 6'h01, 16'hA000, 2'b00);
    step(0, 1, 1, 3'd1, 16'hA001, 1, 0, 3'd1, 16'hB001, 1, 0, 6'h02, 16'hA001, 2'b01);
    step(0, 1, 1, 3'd2, 16'hA002, 1, 0, 3'd1, 16'hB001, 1, 0, 6'h04, 16'hA002, 2'b01);
    step(0, 1, 1, 3'd3, 16'hA003, 1, 0, 3'd1, 16'hB001, 1, 0, 6'h08, 16'hA003, 2'b01);
    step(0, 1, 1, 3'd4, 16'hA004, 1, 0, 3'd1, 16'hB001, 0, 1, 6'h02, 16'hB001, 2'b00);
    step(0, 1, 1, 3'd4, 16'hA004, 1, 0, 3'd1, 16'hB001, 1, 0, 6'h10, 16'hA004, 2'b00);
    // Owner drops lock with no request: idle cycle still owned, B next
    step(0, 0, 0, 3'd5, 16'hA005, 1, 0, 3'd1, 16'hB001, 0, 0, 6'h00, 16'h0000, 2'b01);
    step(0, 0, 0, 3'd5, 16'hA005, 1, 0, 3'd1, 16'hB001, 0, 1, 6'h02, 16'hB001, 2'b00);

    // Voluntary release after a single locked grant, waiting B served after
    step(0, 1, 1, 3'd3, 16'hC003, 1, 0, 3'd0, 16'hD000, 1, 0, 6'h08, 16'hC003, 2'b00);
    step(0, 0, 0, 3'd3, 16'hC003, 1, 0, 3'd0, 16'hD000, 0, 0, 6'h00, 16'h0000, 2'b01);
    step(0, 0, 0, 3'd3, 16'hC003, 1, 0, 3'd0, 16'hD000, 0, 1, 6'h01, 16'hD000, 2'b00);

    // Out-of-range addresses: granted, no strobe
    step(0, 0, 0, 3'd0, 16'h0000, 1, 0, 3'd7, 16'hEEEE, 0, 1, 6'h00, 16'hEEEE, 2'b00);
    step(0, 1, 0, 3'd6, 16'hFFFF, 0, 0, 3'd0, 16'h0000, 1, 0, 6'h00, 16'hFFFF, 2'b00);
    check_bank("bank_bad_addr", 16'hD000, 16'hB001, 16'hA002, 16'hC003, 16'hA004, 16'h2222);

    // Reset in the middle of a B burst (cnt=2)
    step(0, 1, 0, 3'd0, 16'h0AAA, 1, 1, 3'd5, 16'h5555, 0, 1, 6'h20, 16'h5555, 2'b00);
    step(0, 1, 0, 3'd0, 16'h0AAA, 1, 1, 3'd4, 16'h4444, 0, 1, 6'h10, 16'h4444, 2'b10);
    step(1, 1, 0, 3'd0, 16'h0AAA, 1, 1, 3'd3, 16'h3333, 0, 0, 6'h00, 16'h0000, 2'b00);
    step(0, 1, 0, 3'd0, 16'h0AAA, 1, 0, 3'd3, 16'h3333, 1, 0, 6'h01, 16'h0AAA, 2'b00);
    step(0, 0, 0, 3'd0, 16'h0000, 0, 0, 3'd0, 16'h0000, 0, 0, 6'h00, 16'h0000, 2'b00);
    check_bank("bank_final", 16'h0AAA, 16'hB001, 16'hA002, 16'hC003, 16'h4444, 16'h5555);

    // Let the monitor drain, bounded
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
